// File: rtl/ads98xx_config_sequencer.sv
// Walks a table of {addr, data} entries through an SPI master: one write per entry,
// optionally followed by a read-back compare, with per-state timeouts and abort handling.
module ads98xx_config_sequencer #(
    parameter int          NUM_REGS   = 8,
    parameter bit          VERIFY_EN  = 1'b1,
    parameter logic [7:0]  RD_ADDR_OR = 8'h00,
    parameter int          TIMEOUT    = 1023
) (
    input  logic                    spi_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [3:0]              cfg_count,
    input  logic [NUM_REGS*24-1:0]  cfg_table,
    output logic                    tx_trn,
    output logic                    rx_trn,
    output logic [7:0]              addr,
    output logic [15:0]             wr_data,
    input  logic                    spi_busy,
    input  logic                    spi_read_done,
    input  logic [23:0]             read_data,
    output logic                    seq_busy,
    output logic                    seq_done,
    output logic                    seq_error,
    output logic [3:0]              err_index,
    output logic [1:0]              err_code,
    output logic [15:0]             rd_word
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR_REQ, S_WR_WAIT, S_RD_REQ,
        S_RD_WAIT, S_CHECK, S_NEXT, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] CODE_START_TO = 2'b01;
    localparam logic [1:0] CODE_END_TO   = 2'b10;
    localparam logic [1:0] CODE_MISMATCH = 2'b11;
    localparam logic [9:0] TMO           = 10'(TIMEOUT);
    localparam logic [4:0] NREGS5        = 5'(NUM_REGS);

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   count_q, count_d;
    logic         abort_q, abort_d;
    logic [9:0]   tmo_q;
    logic [7:0]   ent_addr_q;
    logic [15:0]  ent_data_q;
    logic [7:0]   addr_q;
    logic [15:0]  wr_data_q;
    logic [15:0]  rd_word_q;
    logic         tx_req_q, rx_req_q;
    logic         seq_busy_q, seq_done_q, seq_error_q;
    logic [3:0]   err_index_q;
    logic [1:0]   err_code_q;

    logic [23:0]  entry_s;
    logic [3:0]   count_clamp_s;
    logic         expire_s;
    logic         abort_any_s;
    logic         accept_s;
    logic [1:0]   fail_code_s;
    logic         unused_s;

    assign expire_s      = (tmo_q >= (TMO - 10'd1));
    assign abort_any_s   = abort_q | abort;
    assign count_clamp_s = ({1'b0, cfg_count} > NREGS5) ? NREGS5[3:0] : cfg_count;
    assign unused_s      = ^read_data[23:16];

    // Select the table entry addressed by the current index.
    always_comb begin
        entry_s = 24'h000000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == 4'(i)) begin
                entry_s = cfg_table[24*i +: 24];
            end else begin
                entry_s = entry_s;
            end
        end
    end

    // Next-state logic; abort requests are remembered until the current frame ends.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        abort_d     = abort_q | abort;
        accept_s    = 1'b0;
        fail_code_s = 2'b00;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start && !abort) begin
                    accept_s = 1'b1;
                    idx_d    = 4'd0;
                    count_d  = count_clamp_s;
                    if (count_clamp_s == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort_any_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                // Busy wins over a same-cycle abort: the frame has started, so it must finish.
                if (spi_busy) begin
                    state_d = (state_q == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
                end else if (abort_any_s) begin
                    state_d = S_IDLE;
                end else if (expire_s) begin
                    state_d     = S_ERR;
                    fail_code_s = CODE_START_TO;
                end else begin
                    state_d = state_q;
                end
            end
            S_WR_WAIT: begin
                if (!spi_busy) begin
                    if (abort_any_s) begin
                        state_d = S_IDLE;
                    end else if (VERIFY_EN) begin
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (expire_s) begin
                    state_d     = S_ERR;
                    fail_code_s = CODE_END_TO;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (!spi_busy && abort_any_s) begin
                    state_d = S_IDLE;
                end else if (!spi_busy && spi_read_done) begin
                    state_d = S_CHECK;
                end else if (expire_s) begin
                    state_d     = S_ERR;
                    fail_code_s = CODE_END_TO;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_CHECK: begin
                if (rd_word_q != ent_data_q) begin
                    state_d     = S_ERR;
                    fail_code_s = CODE_MISMATCH;
                end else if (abort_any_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort_any_s) begin
                    state_d = S_IDLE;
                end else if (idx_q == (count_q - 4'd1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered output updates.
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            count_q     <= 4'd0;
            abort_q     <= 1'b0;
            tmo_q       <= 10'd0;
            ent_addr_q  <= 8'h00;
            ent_data_q  <= 16'h0000;
            addr_q      <= 8'h00;
            wr_data_q   <= 16'h0000;
            rd_word_q   <= 16'h0000;
            tx_req_q    <= 1'b0;
            rx_req_q    <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            seq_error_q <= 1'b0;
            err_index_q <= 4'd0;
            err_code_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            abort_q    <= abort_d;
            tx_req_q   <= (state_d == S_WR_REQ);
            rx_req_q   <= (state_d == S_RD_REQ);
            seq_busy_q <= (state_d != S_IDLE);
            seq_done_q <= (state_d == S_DONE);

            // Counter restarts on every state change and sticks at the limit.
            if (state_d != state_q) begin
                tmo_q <= 10'd0;
            end else if (tmo_q < TMO) begin
                tmo_q <= tmo_q + 10'd1;
            end

            if (state_q == S_LOAD) begin
                ent_addr_q <= entry_s[23:16];
                ent_data_q <= entry_s[15:0];
                addr_q     <= entry_s[23:16];
                wr_data_q  <= entry_s[15:0];
            end else if ((state_q != S_RD_REQ) && (state_d == S_RD_REQ)) begin
                addr_q <= ent_addr_q | RD_ADDR_OR;
            end

            if ((state_q == S_RD_WAIT) && (state_d == S_CHECK)) begin
                rd_word_q <= read_data[15:0];
            end

            if (state_d == S_ERR) begin
                seq_error_q <= 1'b1;
                err_index_q <= idx_q;
                err_code_q  <= fail_code_s;
            end else if (accept_s) begin
                seq_error_q <= 1'b0;
                err_index_q <= 4'd0;
                err_code_q  <= 2'b00;
            end
        end
    end

    // Triggers are masked by busy so a request never overlaps a running frame.
    assign tx_trn    = tx_req_q & ~spi_busy;
    assign rx_trn    = rx_req_q & ~spi_busy;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign seq_busy  = seq_busy_q;
    assign seq_done  = seq_done_q;
    assign seq_error = seq_error_q;
    assign err_index = err_index_q;
    assign err_code  = err_code_q;
    assign rd_word   = rd_word_q;

endmodule

// File: tb/tb_ads98xx_config_sequencer.sv
// Bench for ads98xx_config_sequencer: SPI slave model with register memory, directed
// vector table, hand-written corner sequences and randomized runs against a frame-level reference.
module tb_ads98xx_config_sequencer;

    localparam int         NR   = 8;
    localparam int         TMO  = 16;
    localparam logic [7:0] RDOR = 8'h80;

    logic              spi_clk = 1'b0;
    logic              rst, start, abort;
    logic [3:0]        cfg_count;
    logic [NR*24-1:0]  cfg_table;
    logic              tx_trn, rx_trn;
    logic [7:0]        addr;
    logic [15:0]       wr_data;
    logic              spi_busy, spi_read_done;
    logic [23:0]       read_data;
    logic              seq_busy, seq_done, seq_error;
    logic [3:0]        err_index;
    logic [1:0]        err_code;
    logic [15:0]       rd_word;

    always #5 spi_clk = ~spi_clk;

    ads98xx_config_sequencer #(
        .NUM_REGS(NR), .VERIFY_EN(1'b1), .RD_ADDR_OR(RDOR), .TIMEOUT(TMO)
    ) dut (
        .spi_clk(spi_clk), .rst(rst), .start(start), .abort(abort),
        .cfg_count(cfg_count), .cfg_table(cfg_table),
        .tx_trn(tx_trn), .rx_trn(rx_trn), .addr(addr), .wr_data(wr_data),
        .spi_busy(spi_busy), .spi_read_done(spi_read_done), .read_data(read_data),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error),
        .err_index(err_index), .err_code(err_code), .rd_word(rd_word)
    );

    int          checks = 0;
    int          failures = 0;
    int          proto_bad = 0;
    logic [24:0] frames[$];
    logic [24:0] expq[$];
    logic [15:0] mem [256];
    bit          no_busy = 1'b0, stuck_busy = 1'b0, model_clear = 1'b0, poke_start = 1'b0;
    int          lat = 1, blen = 2, corrupt_rd = -1, rd_seen = 0;
    logic [7:0]  ent_a [NR];
    logic [15:0] ent_d [NR];

    typedef struct {
        logic [3:0]  count;
        int          corrupt;
        int          lt;
        int          bl;
        int          exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [3:0]  exp_idx;
        int          exp_frames;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // SPI slave: latches a frame on trigger, raises busy after lat cycles for blen+1 cycles.
    initial begin
        int          phase, cnt;
        bit          cur_rd;
        logic [7:0]  cur_addr;
        logic [15:0] val;
        phase = 0; cnt = 0; cur_rd = 1'b0; cur_addr = 8'h00;
        spi_busy = 1'b0; spi_read_done = 1'b0; read_data = 24'h000000;
        forever begin
            @(negedge spi_clk);
            spi_read_done = 1'b0;
            if (model_clear) begin
                phase = 0;
                spi_busy = 1'b0;
            end else if (phase == 0) begin
                if ((tx_trn || rx_trn) && !no_busy) begin
                    frames.push_back({rx_trn, addr, (rx_trn ? 16'h0000 : wr_data)});
                    cur_rd = rx_trn;
                    cur_addr = addr;
                    if (tx_trn) mem[addr] = wr_data;
                    phase = 1;
                    cnt = lat;
                end
            end else if (phase == 1) begin
                if (cnt == 0) begin
                    spi_busy = 1'b1;
                    phase = 2;
                    cnt = blen;
                end else cnt--;
            end else if (!stuck_busy) begin
                if (cnt == 0) begin
                    spi_busy = 1'b0;
                    phase = 0;
                    if (cur_rd) begin
                        val = mem[cur_addr & 8'h7F];
                        if (rd_seen == corrupt_rd) val = val + 16'd1;
                        rd_seen++;
                        read_data = {8'hA5, val};
                        spi_read_done = 1'b1;
                    end
                end else cnt--;
            end
        end
    end

    // Trigger protocol watcher.
    initial begin
        forever begin
            @(posedge spi_clk);
            #1;
            if ((tx_trn && rx_trn) || ((tx_trn || rx_trn) && spi_busy)) proto_bad++;
        end
    end

    task automatic do_reset();
        rst = 1'b1; model_clear = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge spi_clk);
        #1;
        rst = 1'b0; model_clear = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < NR; i++) cfg_table[24*i +: 24] = {ent_a[i], ent_d[i]};
    endtask

    task automatic run_seq(input int abort_frame, output int done_n, output int tx_cyc);
        bit seen, fin, aborted, poked;
        done_n = 0; tx_cyc = 0; seen = 1'b0; fin = 1'b0; aborted = 1'b0; poked = 1'b0;
        rd_seen = 0;
        frames.delete();
        start = 1'b1;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(posedge spi_clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            if (seq_done) done_n++;
            if (tx_trn) tx_cyc++;
            if (abort_frame >= 0 && !aborted && frames.size() == abort_frame && spi_busy) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            if (poke_start && seq_busy && !poked && frames.size() == 1) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (seq_busy) seen = 1'b1;
            else if (seen) fin = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("run_completes", fin, 1'b1);
    endtask

    function automatic bit frames_match();
        if (frames.size() != expq.size()) return 1'b0;
        for (int i = 0; i < frames.size(); i++) if (frames[i] !== expq[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        int          d, t, n, k, hit;
        logic [15:0] exp_rd, prev_rd;
        logic        exp_err;

        vecs[0] = '{4'd2,  -1, 1, 2, 1, 1'b0, 2'b00, 4'd0, 4,  16'h00FF};
        vecs[1] = '{4'd2,   0, 1, 2, 0, 1'b1, 2'b11, 4'd0, 2,  16'h1235};
        vecs[2] = '{4'd0,  -1, 1, 2, 1, 1'b0, 2'b00, 4'd0, 0,  16'h0000};
        vecs[3] = '{4'd15, -1, 0, 1, 1, 1'b0, 2'b00, 4'd0, 16, 16'h0F0F};
        vecs[4] = '{4'd3,   2, 2, 0, 0, 1'b1, 2'b11, 4'd2, 6,  16'hBEF0};
        vecs[5] = '{4'd1,  -1, 3, 5, 1, 1'b0, 2'b00, 4'd0, 2,  16'h1234};

        ent_a[0] = 8'h10; ent_d[0] = 16'h1234;
        ent_a[1] = 8'h14; ent_d[1] = 16'h00FF;
        ent_a[2] = 8'h18; ent_d[2] = 16'hBEEF;
        ent_a[3] = 8'h1C; ent_d[3] = 16'h0001;
        ent_a[4] = 8'h20; ent_d[4] = 16'h8000;
        ent_a[5] = 8'h24; ent_d[5] = 16'hFFFF;
        ent_a[6] = 8'h28; ent_d[6] = 16'h5A5A;
        ent_a[7] = 8'h2C; ent_d[7] = 16'h0F0F;
        load_table();
        cfg_count = 4'd0;

        do_reset();
        chk("reset_outputs", {tx_trn, rx_trn, addr, wr_data, seq_busy, seq_done,
                              seq_error, err_index, err_code, rd_word}, 64'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            cfg_count = vecs[v].count; lat = vecs[v].lt; blen = vecs[v].bl;
            corrupt_rd = vecs[v].corrupt;
            run_seq(-1, d, t);
            chk($sformatf("vec%0d_done", v), d, vecs[v].exp_done);
            chk($sformatf("vec%0d_error", v), seq_error, vecs[v].exp_err);
            chk($sformatf("vec%0d_code", v), err_code, vecs[v].exp_code);
            chk($sformatf("vec%0d_index", v), err_index, vecs[v].exp_idx);
            chk($sformatf("vec%0d_frames", v), frames.size(), vecs[v].exp_frames);
            chk($sformatf("vec%0d_rdword", v), rd_word, vecs[v].exp_rd);
        end
        corrupt_rd = -1; lat = 1; blen = 2;

        // Write trigger never acknowledged: start timeout after exactly TMO trigger cycles.
        do_reset();
        cfg_count = 4'd2; no_busy = 1'b1;
        run_seq(-1, d, t);
        chk("start_to_tx_cycles", t, TMO);
        chk("start_to_code", err_code, 2'b01);
        chk("start_to_index", err_index, 4'd0);
        chk("start_to_error", seq_error, 1'b1);
        chk("start_to_done", d, 0);
        no_busy = 1'b0;

        // Busy never released: end timeout.
        do_reset();
        stuck_busy = 1'b1;
        run_seq(-1, d, t);
        chk("end_to_code", err_code, 2'b10);
        chk("end_to_index", err_index, 4'd0);
        chk("end_to_done", d, 0);
        stuck_busy = 1'b0; model_clear = 1'b1;
        repeat (2) @(posedge spi_clk);
        #1;
        model_clear = 1'b0;

        // Abort before busy is seen drops the trigger at once.
        do_reset();
        no_busy = 1'b1;
        start = 1'b1;
        @(posedge spi_clk); #1; start = 1'b0;
        @(posedge spi_clk); #1;
        chk("abort_req_tx_before", tx_trn, 1'b1);
        abort = 1'b1;
        @(posedge spi_clk); #1; abort = 1'b0;
        chk("abort_req_idle", {tx_trn, seq_busy, seq_error}, 3'b000);
        no_busy = 1'b0;

        // Start together with abort in IDLE is not accepted.
        frames.delete();
        start = 1'b1; abort = 1'b1;
        @(posedge spi_clk); #1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge spi_clk);
        #1;
        chk("start_abort_idle", {seq_busy, 8'(frames.size())}, 9'd0);

        // Abort during WR_WAIT of entry 1 of 3.
        do_reset();
        cfg_count = 4'd3; blen = 6;
        run_seq(3, d, t);
        chk("abort_wait_done", d, 0);
        chk("abort_wait_error", seq_error, 1'b0);
        chk("abort_wait_frames", frames.size(), 3);
        t = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge spi_clk); #1;
            if (tx_trn || rx_trn) t++;
        end
        chk("abort_quiet", {t, 8'(frames.size())}, {32'd0, 8'd3});

        // Start while busy is ignored.
        do_reset();
        cfg_count = 4'd2; blen = 2; poke_start = 1'b1;
        run_seq(-1, d, t);
        poke_start = 1'b0;
        chk("restart_ignored_frames", frames.size(), 4);
        chk("restart_ignored_done", d, 1);

        // Reset during RD_WAIT, then a clean rerun.
        do_reset();
        cfg_count = 4'd2; blen = 6;
        frames.delete(); rd_seen = 0;
        start = 1'b1;
        hit = 0;
        for (int c = 0; c < 500 && hit == 0; c++) begin
            @(posedge spi_clk); #1;
            start = 1'b0;
            if (frames.size() == 2 && spi_busy) hit = 1;
        end
        chk("rdwait_reached", hit, 1);
        rst = 1'b1; model_clear = 1'b1;
        @(posedge spi_clk); #1;
        chk("midframe_reset_outputs", {tx_trn, rx_trn, addr, wr_data, seq_busy, seq_done,
                                       seq_error, err_index, err_code, rd_word}, 64'd0);
        rst = 1'b0; model_clear = 1'b0;
        @(posedge spi_clk); #1;
        blen = 2;
        run_seq(-1, d, t);
        chk("rerun_done", d, 1);
        chk("rerun_frames", frames.size(), 4);
        chk("rerun_rdword", rd_word, 16'h00FF);

        // Randomized runs against the frame-level reference.
        do_reset();
        prev_rd = 16'h0000;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NR; i++) begin
                ent_a[i] = 8'($urandom_range(0, 127));
                ent_d[i] = 16'($urandom);
            end
            load_table();
            cfg_count = 4'($urandom_range(0, 15));
            lat = $urandom_range(0, 3);
            blen = $urandom_range(0, 4);
            k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NR - 1) : -1;
            corrupt_rd = k;
            n = (cfg_count > NR) ? NR : int'(cfg_count);
            exp_err = (k >= 0 && k < n);
            expq.delete();
            for (int i = 0; i < n; i++) begin
                expq.push_back({1'b0, ent_a[i], ent_d[i]});
                expq.push_back({1'b1, ent_a[i] | RDOR, 16'h0000});
                if (exp_err && i == k) break;
            end
            if (n == 0) exp_rd = prev_rd;
            else if (exp_err) exp_rd = ent_d[k] + 16'd1;
            else exp_rd = ent_d[n-1];
            prev_rd = exp_rd;
            run_seq(-1, d, t);
            chk("rand_done", d, exp_err ? 0 : 1);
            chk("rand_error", seq_error, exp_err);
            chk("rand_code", err_code, exp_err ? 2'b11 : 2'b00);
            chk("rand_index", err_index, exp_err ? 4'(k) : 4'd0);
            chk("rand_rdword", rd_word, exp_rd);
            chk("rand_frames", frames_match(), 1'b1);
        end

        chk("trigger_protocol", proto_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
